// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   MAX_WIDTH : largest supported operand width
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_add.sv
// Gate-level one-bit full adder cell.
// Ports:
//   a, b : addend bits
//   c    : carry in
//   sum  : sum bit
//   cout : carry out
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    logic half;

    assign half = a ^ b;
    assign sum  = half ^ c;
    assign cout = (a & b) | (c & half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full_add cell processes one bit pair per
// clock, LSB first, with the carry recirculated through a flop.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   a, b  : WIDTH-bit operands, captured on accept
//   cin   : carry-in, captured on accept
//   busy  : high while the operation is running
//   done  : one-cycle pulse when sum/cout update
//   sum   : WIDTH-bit result, held until the next completion
//   cout  : final carry-out, held with sum
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit keeps the width non-zero when WIDTH=1.
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_sum;
    logic             fa_cout;

    full_add u_full_add (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c    (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (cnt == LAST);

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // produced first has arrived at bit 0.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    // busy is registered, so it is high only for the RUN
                    // edges that are followed by another RUN cycle.
                    busy   <= !last;
                    if (last) begin
                        sum  <= res_next;
                        cout <= fa_cout;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       cin8, cin1;
    logic       busy8, done8, cout8;
    logic       busy1, done1, cout1;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitors: pop and compare whenever done is presented.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done8: got done with empty queue, expected none");
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e.sum));
                chk("cout8", 32'(cout8), 32'(e.cout));
                chk("latency8", 32'(cyc - e.acc), 32'd8);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done1: got done with empty queue, expected none");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum1", 32'(sum1), 32'(e.sum[0]));
                chk("cout1", 32'(cout1), 32'(e.cout));
                chk("latency1", 32'(cyc - e.acc), 32'd1);
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input bit push, input logic [7:0] es, input logic ec);
        exp_t e;
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        if (push) begin
            e.sum = es; e.cout = ec; e.acc = cyc + 1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; cin8 = ~cv;
    endtask

    task automatic issue1(input logic av, input logic bv, input logic cv,
                          input logic es, input logic ec);
        exp_t e;
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        e.sum = {7'd0, es}; e.cout = ec; e.acc = cyc + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done8(input int exp_busy);
        int nb = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1;
            else if (busy8) nb++;
        end
        chk("done8_seen", 32'(seen), 32'd1);
        chk("busy8_cycles", 32'(nb), 32'(exp_busy));
        @(posedge clk); #1;
    endtask

    task automatic wait_done1();
        int nb = 0;
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done1) seen = 1;
            else if (busy1) nb++;
        end
        chk("done1_seen", 32'(seen), 32'd1);
        chk("busy1_cycles", 32'(nb), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v;
        logic [1:0] ref_v;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_sum8", 32'(sum8), 0);
        chk("rst_cout8", 32'(cout8), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_done1", 32'(done1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy8", 32'(busy8), 0);
            chk("idle_sum8", 32'(sum8), 0);
            chk("idle_cout8", 32'(cout8), 0);
            chk("idle_busy1", 32'(busy1), 0);
        end
        @(posedge clk); #1;

        // 0F + 01 + 0 = 0_10
        issue8(8'h0F, 8'h01, 1'b0, 1, 8'h10, 1'b0);
        wait_done8(7);

        // FF + 01 + 0 = 1_00
        issue8(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1);
        wait_done8(7);

        // FF + FF + 1 = 1_FF, with an ignored start mid-run
        issue8(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("ignored_start_busy8", 32'(busy8), 0);
        end
        chk("held_sum8", 32'(sum8), 32'h0FF);
        chk("held_cout8", 32'(cout8), 1);
        @(posedge clk); #1;

        // Reset in the 4th RUN cycle of AA + 55
        issue8(8'hAA, 8'h55, 1'b0, 0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_done8", 32'(done8), 0);
        chk("abort_sum8", 32'(sum8), 0);
        chk("abort_cout8", 32'(cout8), 0);
        chk("abort_busy8", 32'(busy8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue8(8'hAA, 8'h55, 1'b0, 1, 8'hFF, 1'b0);
        wait_done8(7);

        // WIDTH=1 truth table, {a,b,cin} = 000 .. 111
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            ref_v = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            issue1(v[2], v[1], v[0], ref_v[0], ref_v[1]);
            wait_done1();
        end

        repeat (4) @(posedge clk);
        chk("q8_drained", 32'(q8.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
